vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates the VGA raster for the display path. Default mode is 640x480 at 60 Hz, from a 25 MHz vga_clk.
- Supplies DrawX/DrawY/blank to the color mapper and its sprite, background and health modules. Drives hs/vs to the VGA connector.
- The sprite and background ROMs are registered on vga_clk, so sync and blank are delayed by a configurable pipeline to stay aligned with the pixel data.
- Also provides a once-per-frame tick and a frame counter, used by game logic for movement, animation and KO timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 1, register stages on hs/vs/blank relative to DrawX/DrawY. Legal range 1..3; any other value is an elaboration error.

Ports:
- vga_clk, in, 1, pixel clock; all state on rising edge
- reset_n, in, 1, asynchronous active-low reset
- DrawX, out, 10, current horizontal count 0..H_TOTAL-1
- DrawY, out, 10, current vertical count 0..V_TOTAL-1
- hs, out, 1, horizontal sync, active-low
- vs, out, 1, vertical sync, active-low
- blank, out, 1, 1 = visible pixel, 0 = blanking (same polarity the sprite modules consume)
- frame_tick, out, 1, one-cycle pulse at start of vertical blanking
- frame_count, out, 16, number of frame_ticks since reset, wrapping

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both are local constants.
- Counters hc and vc are flops driven directly onto DrawX/DrawY (zero latency).
  - Each edge: hc = (hc==H_TOTAL-1) ? 0 : hc+1.
  - vc advances only when hc==H_TOTAL-1: vc = (vc==V_TOTAL-1) ? 0 : vc+1.
- Raw decodes from the current hc/vc:
  - hs_raw = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491). This covers whole lines, regardless of hc.
  - blank_raw = 1 iff hc < H_ACTIVE && vc < V_ACTIVE.
- Delay line: hs/vs/blank pass through exactly PIPE_DLY flop stages, so hs(t) = hs_raw(t-PIPE_DLY), and likewise for vs and blank. Outputs are flop-driven and glitch-free.
- frame_tick is a flop output. It is high for exactly the one cycle in which DrawX==0 and DrawY==V_ACTIVE, and low otherwise. It is not delayed by PIPE_DLY.
- frame_count increments by 1 on the clock edge that ends a frame_tick cycle. It wraps 0xFFFF -> 0x0000 with no flag.
- Reset (asynchronous assert, synchronous-safe release):
  - hc=0, vc=0, frame_count=0, frame_tick=0.
  - All delay stages load their idle values: hs=1, vs=1, blank=0.
  - The first edge after reset_n rises moves DrawX to 1.
- Reset mid-frame: all of the above apply immediately, whatever the counter position. No partial sync pulse may continue after reset is asserted.
- Wrap at (799,524): DrawX=0 and DrawY=0 on the same edge. vs is already high there (sync ended at line 491).
- With PIPE_DLY=1 and reset just released, blank stays 0 for the first cycle. It then follows blank_raw, so the first visible pixel (0,0) is marked one cycle late. This is intentional and matches the 1-cycle ROM latency.

Decomposition:
- Shared package vga_pkg holds:
  - timing localparams for the default mode (H_*/V_* values and H_TOTAL/V_TOTAL);
  - the 10-bit coordinate typedef, shared with the color mapper and sprite modules.
- One sub-module is natural: sync_delay, a parameterized N-stage shift register with a per-bit reset value, instanced once over {hs_raw, vs_raw, blank_raw}.
- Counters and decode stay in the top module.

Test Plan:
- Reset then release, PIPE_DLY=1 -> DrawX=0, DrawY=0, hs=1, vs=1, blank=0 during reset; after 5 edges DrawX=5, DrawY=0.
- Horizontal timing, PIPE_DLY=1 -> blank falls when DrawX==641. hs falls when DrawX==657 and rises when DrawX==753. Line period is 800 clocks; DrawY increments as DrawX goes 799->0.
- Vertical timing -> vs is low from (DrawX=1,DrawY=490) through (DrawX=0,DrawY=492) inclusive, i.e. exactly 1600 clocks. No blank=1 cycles occur for DrawY 480..524.
- Frame tick -> exactly one frame_tick per 420000 clocks, at (0,480). frame_count goes 0->1->2 over two frames. Forcing frame_count to 0xFFFF gives 0x0000 after the next tick.
- Reset mid-frame: assert reset_n=0 at DrawX=700 (inside hsync), DrawY=300 -> hs=1, DrawX=0, DrawY=0 asynchronously, before the next edge. Normal timing resumes after release.
- PIPE_DLY=3 -> hs/vs/blank edges shift 2 cycles later than with PIPE_DLY=1 (e.g. hs falls at DrawX==659). DrawX/DrawY/frame_tick timing is unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz from a 25 MHz pixel clock)
// and the coordinate type used by the color mapper and sprite modules.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value; keeps sync/blank
// aligned with the registered sprite and background ROM data.
module sync_delay #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: zero-latency DrawX/DrawY counters, pipelined
// hs/vs/blank, plus a once-per-frame tick and a wrapping frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  if (PIPE_DLY < 1 || PIPE_DLY > 3) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY must be in 1..3");
  end

  coord_t      hc_q, hc_d;
  coord_t      vc_q, vc_d;
  logic        frame_tick_q, frame_tick_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        line_end;
  logic        hs_raw, vs_raw, blank_raw;
  logic [2:0]  sync_dly;

  always_comb begin
    line_end = (hc_q == H_LAST);
    hc_d     = line_end ? '0 : hc_q + 1'b1;
    vc_d     = vc_q;
    if (line_end) begin
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
    // Registered tick: high in the cycle whose counters read (0, V_ACTIVE).
    frame_tick_d  = (hc_d == '0) && (vc_d == V_ACT);
    frame_count_d = frame_count_q + 16'(frame_tick_q);

    hs_raw    = !((hc_q >= HS_START) && (hc_q < HS_END));
    vs_raw    = !((vc_q >= VS_START) && (vc_q < VS_END));
    blank_raw = (hc_q < H_ACT) && (vc_q < V_ACT);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
    end
  end

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    ({hs_raw, vs_raw, blank_raw}),
    .q_o    (sync_dly)
  );

  assign {hs, vs, blank} = sync_dly;
  assign DrawX           = hc_q;
  assign DrawY           = vc_q;
  assign frame_tick      = frame_tick_q;
  assign frame_count     = frame_count_q;

endmodule
